// File: rtl/partition_sched_pkg.sv
// Shared types and helpers for the partition scheduler: FSM state encoding,
// default geometry of the info FIFO word and a one-hot to index converter.
package partition_sched_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int MAX_ENG        = 16;
    localparam int DEF_NUM_ENG    = 4;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_INFO_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    // Info word layout: len at the bottom, id directly above it, last in the MSB.
    localparam int LEN_LSB = 0;

    function automatic logic [3:0] oh_to_idx(input logic [MAX_ENG-1:0] oh);
        oh_to_idx = '0;
        for (int i = 0; i < MAX_ENG; i++) begin
            if (oh[i]) oh_to_idx = 4'(i);
        end
    endfunction

endpackage

// File: rtl/partition_sched_if.sv
// Bundle of the scheduler's FIFO, engine, batch-handshake and status signals.
// The slave modport is the scheduler's view; master is the surrounding system.
interface partition_sched_if #(
    parameter int NUM_ENG    = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int ID_WIDTH   = 8,
    parameter int INFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [INFO_WIDTH-1:0]         info_fifo_dout;
    logic                          info_fifo_empty;
    logic                          info_fifo_rd_en;
    logic [NUM_ENG-1:0]            eng_start;
    logic [NUM_ENG*ID_WIDTH-1:0]   eng_id;
    logic [NUM_ENG*LEN_WIDTH-1:0]  eng_len;
    logic [NUM_ENG-1:0]            eng_done;
    logic                          paritition_done;
    logic                          process_done;
    logic [CNT_WIDTH-1:0]          batch_parts;
    logic                          sched_err;

    modport slave (
        input  info_fifo_dout, info_fifo_empty, eng_done, paritition_done,
        output info_fifo_rd_en, eng_start, eng_id, eng_len, process_done,
               batch_parts, sched_err
    );

    modport master (
        output info_fifo_dout, info_fifo_empty, eng_done, paritition_done,
        input  info_fifo_rd_en, eng_start, eng_id, eng_len, process_done,
               batch_parts, sched_err
    );
endinterface

// File: rtl/partition_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping around; the pointer itself lives in the caller.
module partition_sched_rr_arb #(
    parameter int NUM_ENG = 4,
    parameter int PTR_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
    input  logic [NUM_ENG-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_ENG-1:0] grant_o,
    output logic               grant_vld_o
);

    always_comb begin
        int  idx;
        logic found;
        // NOTE: combinational blocks use blocking assignments and give every
        // output a default first, so no path leaves a value unassigned (no latch).
        grant_o     = '0;
        grant_vld_o = 1'b0;
        found       = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_ENG; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_ENG) idx = idx - NUM_ENG;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        grant_vld_o = found;
    end

endmodule

// File: rtl/partition_sched.sv
// Pops partition descriptors from the info FIFO, dispatches them round-robin
// to idle engines and closes each batch with the partition block.
module partition_sched
    import partition_sched_pkg::*;
#(
    parameter int NUM_ENG    = DEF_NUM_ENG,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int INFO_WIDTH = DEF_INFO_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input logic              user_clk,
    input logic              user_rst,
    partition_sched_if.slave bus
);

    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    state_e                       state_q, state_d;
    logic [NUM_ENG-1:0]           busy_q, busy_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                         pdone_seen_q, pdone_seen_d;
    logic [CNT_WIDTH-1:0]         batch_parts_q, batch_parts_d;
    logic                         sched_err_q, sched_err_d;
    logic [NUM_ENG-1:0]           eng_start_q, eng_start_d;
    logic [NUM_ENG*ID_WIDTH-1:0]  eng_id_q, eng_id_d;
    logic [NUM_ENG*LEN_WIDTH-1:0] eng_len_q, eng_len_d;

    logic [LEN_WIDTH-1:0] head_len;
    logic [ID_WIDTH-1:0]  head_id;
    logic                 head_last;
    logic                 head_zero;

    logic [NUM_ENG-1:0]   grant;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;

    logic                 pop;
    logic                 dispatch;
    logic                 process_done;

    assign head_len  = bus.info_fifo_dout[LEN_LSB +: LEN_WIDTH];
    assign head_id   = bus.info_fifo_dout[LEN_WIDTH +: ID_WIDTH];
    assign head_last = bus.info_fifo_dout[INFO_WIDTH-1];
    assign head_zero = (head_len == '0);

    partition_sched_rr_arb #(
        .NUM_ENG (NUM_ENG),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .req_i       (~busy_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_vld_o (grant_vld)
    );

    assign grant_idx = PTR_W'(oh_to_idx(MAX_ENG'(grant)));

    // State register.
    always_ff @(posedge user_clk) begin
        if (user_rst) state_q <= S_RUN;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (pop && head_last)                  state_d = S_DRAIN;
            S_DRAIN: if (busy_q == '0 && pdone_seen_q)      state_d = S_DONE;
            S_DONE:  if (!bus.paritition_done)              state_d = S_RUN;
            default:                                        state_d = S_RUN;
        endcase
    end

    // Outputs decoded from state. A zero-length head is consumed even with
    // every engine busy; it is counted but never reaches an engine.
    always_comb begin
        pop          = 1'b0;
        dispatch     = 1'b0;
        process_done = 1'b0;
        unique case (state_q)
            S_RUN: begin
                pop      = !user_rst && !bus.info_fifo_empty && (head_zero || grant_vld);
                dispatch = pop && !head_zero;
            end
            S_DONE:  process_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: engine tracking, dispatch registers, batch bookkeeping.
    always_comb begin
        busy_d      = (busy_q & ~bus.eng_done) | (dispatch ? grant : '0);
        sched_err_d = sched_err_q | (|(bus.eng_done & ~busy_q));
        rr_ptr_d    = rr_ptr_q;
        eng_start_d = '0;
        eng_id_d    = eng_id_q;
        eng_len_d   = eng_len_q;
        if (dispatch) begin
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;
            eng_start_d = grant;
            eng_id_d[int'(grant_idx)*ID_WIDTH +: ID_WIDTH]    = head_id;
            eng_len_d[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH] = head_len;
        end

        pdone_seen_d  = pdone_seen_q;
        batch_parts_d = batch_parts_q;
        if (state_q == S_DONE) begin
            if (!bus.paritition_done) begin
                pdone_seen_d  = 1'b0;
                batch_parts_d = '0;
            end
        end else begin
            if (bus.paritition_done) pdone_seen_d = 1'b1;
            if (pop && batch_parts_q != '1) batch_parts_d = batch_parts_q + 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        // NOTE: every register here, including the per-engine id/len holding
        // registers, is reset so all outputs read 0 straight out of reset.
        if (user_rst) begin
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            pdone_seen_q  <= 1'b0;
            batch_parts_q <= '0;
            sched_err_q   <= 1'b0;
            eng_start_q   <= '0;
            eng_id_q      <= '0;
            eng_len_q     <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            pdone_seen_q  <= pdone_seen_d;
            batch_parts_q <= batch_parts_d;
            sched_err_q   <= sched_err_d;
            eng_start_q   <= eng_start_d;
            eng_id_q      <= eng_id_d;
            eng_len_q     <= eng_len_d;
        end
    end

    assign bus.info_fifo_rd_en = pop;
    assign bus.eng_start       = eng_start_q;
    assign bus.eng_id          = eng_id_q;
    assign bus.eng_len         = eng_len_q;
    assign bus.process_done    = process_done;
    assign bus.batch_parts     = batch_parts_q;
    assign bus.sched_err       = sched_err_q;

endmodule
